coordinate_collector: RTL and testbench
=======================================

# coordinate_collector

Operator-facing front end of the pathfinding accelerator. It captures 8-bit (x, y) coordinate pairs from switch inputs on each press of an "enter" button and writes each pair into parallel x/y coordinate memories at consecutive addresses. It shows the live inputs and the stored-pair count on six hex digits, and raises `done` when the operator finishes initialisation or the memory fills.

## Interface
Parameters:
- none (memory depth fixed at 256 entries, see Structure)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high; one clock and this reset, nothing else
- `x_in` in 8: x coordinate from switches
- `y_in` in 8: y coordinate from switches
- `write_en` in 1: level enable; a capture happens only while high
- `enterNewCoord` in 1: enter button (level; rising edge is the command)
- `finishInit` in 1: level; ends collection
- `x_out` out 8: x data to x memory
- `y_out` out 8: y data to y memory
- `update_x_mem` out 1: x memory write strobe
- `update_y_mem` out 1: y memory write strobe
- `mem_wren` out 1: combined memory write enable
- `address` out 8: write address = number of pairs stored so far
- `hex0`..`hex5` out 4 each: hex digit nibbles
- `done` out 1: collection finished (sticky)

## Operation
- Edge detect: `enter_q` registers `enterNewCoord`; `rise = enterNewCoord & ~enter_q`. Holding the button gives exactly one command.
- States: IDLE, WRITE, DONE.
- IDLE:
  - `finishInit`=1 → DONE. This has priority over `rise` in the same cycle.
  - Else if `rise & write_en` → latch `x_in`/`y_in` into `x_out`/`y_out`, go to WRITE.
  - A `rise` while `write_en`=0 is discarded, not queued.
- WRITE (exactly 1 cycle):
  - `mem_wren`=`update_x_mem`=`update_y_mem`=1.
  - `address`=current count; `x_out`/`y_out` hold the latched pair.
  - Next cycle: count increments, wrapping 8-bit.
  - If the count was 255 or `finishInit`=1 → DONE, else IDLE.
- DONE: `done`=1, all strobes 0, every input ignored; exit only via `reset`.
- `address` is always the count register. `x_out`/`y_out` hold the last latched pair between writes.
- Hex digits, registered each cycle:
  - `hex1:hex0` = `y_in[7:4]:y_in[3:0]`
  - `hex3:hex2` = `x_in[7:4]:x_in[3:0]`
  - `hex5:hex4` = count high:low nibble
- Reset values: state IDLE; count, `address`, `x_out`, `y_out`, all hex digits, `enter_q` = 0; all strobes 0; `done`=0.
- Reset asserted mid-WRITE aborts the write: strobes are 0 from the next edge and the count is not incremented.

## Timing
- Edge N: `enterNewCoord` sampled 1 while `enter_q`=0 and `write_en`=1.
- Cycle N+1: WRITE, strobes high for one cycle, `address`=k.
- Cycle N+2: `address`=k+1, IDLE.
- Minimum 2 cycles per pair. A new `rise` seen during WRITE is ignored; the button must be released and pressed again.
- `done` rises one cycle after `finishInit` is sampled in IDLE. If `finishInit` is sampled in WRITE, `done` rises one cycle after the write.
- Hex digits lag their inputs by one cycle.
- Strobes are never asserted in IDLE or DONE, or in the cycle after reset.

## Structure
- Package `coord_pkg`:
  - state enum `coord_state_t` {IDLE, WRITE, DONE}
  - `COORD_W=8`
  - `MAX_COORDS=256`
  - `HEX_W=4`
- One natural sub-module: `rise_detect`, a registered rising-edge detector for `enterNewCoord`. Everything else is the top FSM, count register and hex registers.

## Test plan
- Reset: hold `reset` 2 cycles → all outputs 0, `done`=0, no strobes.
- Single capture: `write_en`=1, x=0x12, y=0x34, pulse enter → exactly one cycle with `mem_wren`=`update_x_mem`=`update_y_mem`=1, `address`=0, x_out=0x12, y_out=0x34. Afterwards `address`=1 and `hex5:hex4`=0:1.
- Held button and disabled write:
  - enter held 20 cycles → one write only.
  - enter pulsed with `write_en`=0 → no write, `address` unchanged.
- Finish: after 3 writes, assert `finishInit` → `done`=1 next cycle, `address`=3. Further enter pulses produce no strobes.
- Simultaneous: `finishInit` and the enter rise in the same IDLE cycle → DONE, no write.
- Full: 256 captures → last write at `address`=255, then `done`=1 and `address` wraps to 0. Reset mid-WRITE → `address` is 0 and strobes are low on the next cycle.

Source files
------------

// File: rtl/coord_pkg.sv
// Shared types and sizes for the coordinate collector front end.
package coord_pkg;
  localparam int COORD_W    = 8;
  localparam int MAX_COORDS = 256;
  localparam int HEX_W      = 4;
  localparam int ADDR_W     = $clog2(MAX_COORDS);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } coord_state_t;
endpackage

// File: rtl/coordinate_collector_rise_detect.sv
// Registered rising-edge detector: one pulse per low-to-high transition of level_i.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);
  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level_i;
  end

  assign rise_o = level_i & ~level_q;
endmodule

// File: rtl/coordinate_collector.sv
// Captures switch (x, y) pairs on enter presses into parallel coordinate memories,
// shows live inputs and the stored-pair count on six hex digits.
module coordinate_collector
  import coord_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               write_en,
  input  logic               enterNewCoord,
  input  logic               finishInit,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               update_x_mem,
  output logic               update_y_mem,
  output logic               mem_wren,
  output logic [ADDR_W-1:0]  address,
  output logic [HEX_W-1:0]   hex0,
  output logic [HEX_W-1:0]   hex1,
  output logic [HEX_W-1:0]   hex2,
  output logic [HEX_W-1:0]   hex3,
  output logic [HEX_W-1:0]   hex4,
  output logic [HEX_W-1:0]   hex5,
  output logic               done
);
  coord_state_t         state_q, state_d;
  logic [ADDR_W-1:0]    count_q, count_d;
  logic [COORD_W-1:0]   x_q, x_d;
  logic [COORD_W-1:0]   y_q, y_d;
  logic [6*HEX_W-1:0]   hex_q;
  logic                 rise;
  logic                 wr;

  rise_detect u_rise (
    .clk     (clk),
    .reset   (reset),
    .level_i (enterNewCoord),
    .rise_o  (rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hex_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hex_q   <= {count_q, x_in, y_in};
    end
  end

  // finishInit outranks a same-cycle press; a press with write_en low is dropped.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (finishInit) begin
          state_d = DONE;
        end else if (rise && write_en) begin
          x_d     = x_in;
          y_d     = y_in;
          state_d = WRITE;
        end
      end
      WRITE: begin
        count_d = count_q + 1'b1;
        if (count_q == ADDR_W'(MAX_COORDS - 1) || finishInit) state_d = DONE;
        else                                                  state_d = IDLE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign wr           = (state_q == WRITE);
  assign mem_wren     = wr;
  assign update_x_mem = wr;
  assign update_y_mem = wr;
  assign done         = (state_q == DONE);
  assign address      = count_q;
  assign x_out        = x_q;
  assign y_out        = y_q;
  assign {hex5, hex4, hex3, hex2, hex1, hex0} = hex_q;
endmodule

// File: tb/tb_coordinate_collector.sv
// Bench for coordinate_collector: vector table of presses plus scoreboarded write strobes.
module tb_coordinate_collector;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] x_in, y_in;
  logic       write_en, enterNewCoord, finishInit;
  logic [7:0] x_out, y_out, address;
  logic       update_x_mem, update_y_mem, mem_wren, done;
  logic [3:0] hex0, hex1, hex2, hex3, hex4, hex5;

  coordinate_collector dut (
    .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in),
    .write_en(write_en), .enterNewCoord(enterNewCoord), .finishInit(finishInit),
    .x_out(x_out), .y_out(y_out), .update_x_mem(update_x_mem),
    .update_y_mem(update_y_mem), .mem_wren(mem_wren), .address(address),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] x;
    logic [7:0] y;
  } wr_t;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       we;
    logic       hold;
    logic       exp_wr;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[6];
  int   checks = 0;
  int   passes = 0;
  int   exp_count;
  logic [7:0] last_x, last_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Every strobe must match a scoreboarded write.
  always @(negedge clk) begin
    if (mem_wren || update_x_mem || update_y_mem) begin
      chk("strobes_together", {29'd0, mem_wren, update_x_mem, update_y_mem}, 32'd7);
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_address", {24'd0, address}, {24'd0, e.addr});
        chk("wr_x_out", {24'd0, x_out}, {24'd0, e.x});
        chk("wr_y_out", {24'd0, y_out}, {24'd0, e.y});
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; enterNewCoord = 1'b0; finishInit = 1'b0; write_en = 1'b0;
    x_in = 8'h00; y_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_address", {24'd0, address}, 32'd0);
    chk("rst_xy", {16'd0, x_out, y_out}, 32'd0);
    chk("rst_strobes", {29'd0, mem_wren, update_x_mem, update_y_mem}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hex", {8'd0, hex5, hex4, hex3, hex2, hex1, hex0}, 32'd0);
    reset = 1'b0;
    exp_count = 0; last_x = 8'h00; last_y = 8'h00;
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic press(input logic [7:0] x, input logic [7:0] y, input logic we,
                       input logic hold, input logic exp_wr);
    wr_t e;
    x_in = x; y_in = y; write_en = we; enterNewCoord = 1'b1;
    if (exp_wr) begin
      e.addr = exp_count[7:0]; e.x = x; e.y = y;
      sb.push_back(e);
      exp_count = (exp_count + 1) % 256;
      last_x = x; last_y = y;
    end
    repeat (hold ? 20 : 1) @(posedge clk);
    #1 enterNewCoord = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{x: 8'h12, y: 8'h34, we: 1'b1, hold: 1'b0, exp_wr: 1'b1};
    vecs[1] = '{x: 8'h56, y: 8'h78, we: 1'b1, hold: 1'b1, exp_wr: 1'b1};
    vecs[2] = '{x: 8'h9A, y: 8'hBC, we: 1'b0, hold: 1'b0, exp_wr: 1'b0};
    vecs[3] = '{x: 8'hFF, y: 8'h00, we: 1'b1, hold: 1'b0, exp_wr: 1'b1};
    vecs[4] = '{x: 8'h00, y: 8'hFF, we: 1'b0, hold: 1'b1, exp_wr: 1'b0};
    vecs[5] = '{x: 8'hA5, y: 8'h5A, we: 1'b1, hold: 1'b0, exp_wr: 1'b1};

    do_reset();
    @(posedge clk); #1;
    chk("post_rst_no_strobe", {31'd0, mem_wren}, 32'd0);

    // Table: captures, held button, disabled write.
    foreach (vecs[i]) begin
      press(vecs[i].x, vecs[i].y, vecs[i].we, vecs[i].hold, vecs[i].exp_wr);
      chk($sformatf("v%0d_address", i), {24'd0, address}, exp_count);
      chk($sformatf("v%0d_xy_hold", i), {16'd0, x_out, y_out}, {16'd0, last_x, last_y});
      chk($sformatf("v%0d_hex_count", i), {24'd0, hex5, hex4}, exp_count);
      chk($sformatf("v%0d_hex_xy", i), {16'd0, hex3, hex2, hex1, hex0},
          {16'd0, vecs[i].x, vecs[i].y});
      chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd0);
    end
    chk("table_sb_empty", sb.size(), 32'd0);

    // Finish after three writes.
    do_reset();
    for (int i = 0; i < 3; i++) press(8'(i + 1), 8'(i + 16), 1'b1, 1'b0, 1'b1);
    finishInit = 1'b1;
    @(posedge clk); #1;
    chk("fin_done", {31'd0, done}, 32'd1);
    chk("fin_address", {24'd0, address}, 32'd3);
    finishInit = 1'b0;
    for (int i = 0; i < 3; i++) press(8'h77, 8'h88, 1'b1, 1'b0, 1'b0);
    chk("fin_sticky", {31'd0, done}, 32'd1);
    chk("fin_address_kept", {24'd0, address}, 32'd3);
    chk("fin_xy_kept", {16'd0, x_out, y_out}, {16'd0, 8'h03, 8'h12});

    // finishInit and press in the same IDLE cycle.
    do_reset();
    write_en = 1'b1; x_in = 8'h44; y_in = 8'h55;
    enterNewCoord = 1'b1; finishInit = 1'b1;
    @(posedge clk); #1;
    enterNewCoord = 1'b0; finishInit = 1'b0;
    chk("sim_done", {31'd0, done}, 32'd1);
    repeat (3) @(posedge clk); #1;
    chk("sim_address", {24'd0, address}, 32'd0);
    chk("sim_xy", {16'd0, x_out, y_out}, 32'd0);

    // Fill all 256 entries.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      press(8'(i), 8'(255 - i), 1'b1, 1'b0, 1'b1);
      if (i == 254) chk("full_before_last_done", {31'd0, done}, 32'd0);
    end
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_wrap", {24'd0, address}, 32'd0);
    press(8'h11, 8'h22, 1'b1, 1'b0, 1'b0);
    chk("full_sb_empty", sb.size(), 32'd0);

    // Reset asserted during WRITE aborts the count increment.
    do_reset();
    press(8'h01, 8'h02, 1'b1, 1'b0, 1'b1);
    begin
      wr_t e;
      x_in = 8'h3C; y_in = 8'hC3; enterNewCoord = 1'b1;
      e.addr = 8'd1; e.x = 8'h3C; e.y = 8'hC3;
      sb.push_back(e);
      @(posedge clk); #1;
      chk("mid_in_write", {31'd0, mem_wren}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_strobe_low", {31'd0, mem_wren}, 32'd0);
      chk("mid_address", {24'd0, address}, 32'd0);
      reset = 1'b0; enterNewCoord = 1'b0;
      @(posedge clk); #1;
      chk("mid_no_strobe_after", {31'd0, mem_wren}, 32'd0);
      chk("mid_address_after", {24'd0, address}, 32'd0);
      chk("mid_sb_empty", sb.size(), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
